tt_cpu_core: RTL and testbench

Parametrised successor to the fixed 8-bit simple CPU, intended to sit behind a `tt_um_*` pin wrapper.

- Runs a small accumulator machine out of an internal instruction memory that is loaded over a valid/ready port.
- Data width, memory depth and register-file size are parameters.
- Adds a carry flag, conditional branches, an I/O port and an explicit HALT.

---
 rtl/tt_cpu_pkg.sv | 54 +++++
 rtl/tt_cpu_if.sv | 32 +++
 rtl/tt_cpu_alu.sv | 55 +++++
 rtl/tt_cpu_core.sv | 233 +++++++++++++++++++++++
 tb/tb_tt_cpu_core.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_cpu_pkg.sv
// -----------------------------------------------------------------------------
// tt_cpu_pkg
// Shared definitions for the tt_cpu_core accumulator machine: instruction
// word layout, opcode and control-state encodings, and a small decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package tt_cpu_pkg;

  localparam int INSTR_W = 16;

  // Instruction word fields: [15:12] opcode, [11:8] register, [7:0] imm.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int REG_MSB = 11;
  localparam int REG_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_LDR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_IN   = 4'hC,
    OP_OUT  = 4'hD,
    OP_ADDI = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Ops whose result lands in the accumulator (and therefore update Z).
  function automatic logic writes_acc(opcode_e op);
    case (op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LDR, OP_IN, OP_ADDI: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tt_cpu_if.sv
// -----------------------------------------------------------------------------
// tt_cpu_if
// Bus bundle between a host and tt_cpu_core: the program-load valid/ready
// port plus the byte-style I/O port.
//   prog_valid / prog_data / prog_ready : instruction word load handshake
//   in_data                             : value sampled by the IN instruction
//   out_data / out_valid                : OUT register and its one-cycle pulse
// Modports: master = host side, slave = core side.
// DATA_W must match the DATA_W of the core it is connected to.
// -----------------------------------------------------------------------------
interface tt_cpu_if #(
  parameter int DATA_W = 8
);

  logic                           prog_valid;
  logic [tt_cpu_pkg::INSTR_W-1:0] prog_data;
  logic                           prog_ready;
  logic [DATA_W-1:0]              in_data;
  logic [DATA_W-1:0]              out_data;
  logic                           out_valid;

  modport master (
    output prog_valid, prog_data, in_data,
    input  prog_ready, out_data, out_valid
  );

  modport slave (
    input  prog_valid, prog_data, in_data,
    output prog_ready, out_data, out_valid
  );

endinterface

// File: rtl/tt_cpu_alu.sv
// -----------------------------------------------------------------------------
// tt_cpu_alu
// Combinational datapath for the accumulator ops.
//   op      : decoded opcode
//   acc     : current accumulator
//   operand : register value, zero-extended imm or in_data (chosen by core)
//   c_in    : current carry flag
//   result  : new accumulator value (acc itself for non-acc ops)
//   z       : result == 0
//   c_out   : carry/borrow for ADD/ADDI/SUB, otherwise c_in
// -----------------------------------------------------------------------------
module tt_cpu_alu
  import tt_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c_out
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned; that is what keeps always_comb from inferring latches.
    sum    = {1'b0, acc} + {1'b0, operand};
    // The extra top bit of the difference is set exactly when acc < operand.
    diff   = {1'b0, acc} - {1'b0, operand};
    result = acc;
    c_out  = c_in;
    case (op)
      OP_LDI, OP_LDR, OP_IN: result = operand;
      OP_ADD, OP_ADDI: begin
        result = sum[DATA_W-1:0];
        c_out  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        c_out  = diff[DATA_W];
      end
      OP_AND:  result = acc & operand;
      OP_OR:   result = acc | operand;
      OP_XOR:  result = acc ^ operand;
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/tt_cpu_core.sv
// -----------------------------------------------------------------------------
// tt_cpu_core
// Parametrised accumulator CPU. A program is streamed into the internal
// instruction memory while run=0, then executed as FETCH/EXEC pairs while
// run=1. HALT parks the core until run drops.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ena          : global stall; 0 freezes all state and masks out_valid
//   run          : 1 = execute, 0 = return to LOAD
//   bus (slave)  : program load handshake and I/O port (see tt_cpu_if)
//   pc           : current program counter
//   halted       : core is parked in HALT
// Optional build macro CPU_BREAK_EN adds a PC breakpoint:
//   bp_en, bp_addr : breakpoint enable and address
//   bp_hit         : HALT was entered through the breakpoint
// -----------------------------------------------------------------------------
module tt_cpu_core
  import tt_cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int NUM_REGS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          run,
  tt_cpu_if.slave                       bus,
`ifdef CPU_BREAK_EN
  input  logic                          bp_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] bp_addr,
  output logic                          bp_hit,
`endif
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];

  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW:0]        lptr_q, lptr_d;   // one extra bit so "full" is representable
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               halted_q, halted_d;

  // Decode of the instruction register.
  opcode_e            op;
  logic [RW-1:0]      ridx;
  logic [DATA_W-1:0]  imm;
  logic [AW-1:0]      jtarget;
  logic [DATA_W-1:0]  operand;
  logic               unused_ir;

  assign op        = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign ridx      = ir_q[REG_LSB +: RW];
  assign imm       = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
  assign jtarget   = ir_q[IMM_LSB +: AW];
  // Register-index bits above RW are ignored by design.
  assign unused_ir = ^ir_q;

  always_comb begin
    case (op)
      OP_LDI, OP_ADDI: operand = imm;
      OP_IN:           operand = bus.in_data;
      default:         operand = regs_q[ridx];
    endcase
  end

  logic [DATA_W-1:0] alu_result;
  logic              alu_z;
  logic              alu_c;

  tt_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op),
    .acc     (acc_q),
    .operand (operand),
    .c_in    (c_q),
    .result  (alu_result),
    .z       (alu_z),
    .c_out   (alu_c)
  );

  // Load handshake.
  logic prog_ready;
  logic load_fire;

  assign prog_ready = (state_q == LOAD) && !run && !lptr_q[AW];
  assign load_fire  = ena && bus.prog_valid && prog_ready;

  // Breakpoint trip condition, only meaningful in FETCH.
  logic bp_trip;
`ifdef CPU_BREAK_EN
  assign bp_trip = bp_en && (pc_q == bp_addr);
`else
  assign bp_trip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    lptr_d      = lptr_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    regs_d      = regs_q;
    z_d         = z_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;          // pulse only; also masks stalled cycles

    if (ena) begin
      case (state_q)
        LOAD: begin
          if (run) begin
            pc_d    = '0;
            state_d = FETCH;
          end else if (load_fire) begin
            lptr_d = lptr_q + (AW+1)'(1);
          end
        end

        FETCH: begin
          if (bp_trip) begin
            state_d = HALT;      // park without fetching; pc stays on the breakpoint
          end else begin
            ir_d    = imem[pc_q];
            pc_d    = pc_q + AW'(1);
            state_d = EXEC;
          end
        end

        EXEC: begin
          if (writes_acc(op)) begin
            acc_d = alu_result;
            z_d   = alu_z;
          end
          c_d = alu_c;           // the ALU passes c_in through for non-arithmetic ops
          case (op)
            OP_MOV: regs_d[ridx] = acc_q;
            OP_JMP: pc_d = jtarget;
            OP_JZ:  if (z_q) pc_d = jtarget;
            OP_JC:  if (c_q) pc_d = jtarget;
            OP_OUT: begin
              out_data_d  = acc_q;
              out_valid_d = 1'b1;
            end
            default: ;
          endcase
          state_d = (op == OP_HALT) ? HALT : FETCH;
        end

        default: ;               // HALT holds until run drops
      endcase

      // Dropping run aborts execution after the current step has taken effect;
      // registers, acc and flags survive into the next run.
      if (state_q != LOAD && !run) begin
        state_d = LOAD;
        lptr_d  = '0;
        pc_d    = '0;
      end
    end

    halted_d = (state_d == HALT);
  end

  // NOTE: instruction memory has no reset; contents survive rst, and leaving it
  // out of the reset network lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (load_fire) imem[lptr_q[AW-1:0]] <= bus.prog_data;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed in always_comb, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      pc_q        <= '0;
      lptr_q      <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      lptr_q      <= lptr_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      regs_q      <= regs_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

`ifdef CPU_BREAK_EN
  // HALT is reached from FETCH only via the breakpoint, so the flag is set on
  // that transition and held for as long as the core stays in HALT.
  logic bp_hit_q, bp_hit_d;

  assign bp_hit_d = (state_d == HALT) && (bp_hit_q || (state_q == FETCH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bp_hit_q <= 1'b0;
    else     bp_hit_q <= bp_hit_d;
  end

  assign bp_hit = bp_hit_q;
`endif

  assign bus.prog_ready = prog_ready;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign pc             = pc_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_tt_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_tt_cpu_core
// Directed self-checking bench for tt_cpu_core with DATA_W=8, IMEM_DEPTH=16,
// NUM_REGS=4. Inputs are driven on the falling edge, outputs sampled there.
// Edge counts below start at the first rising edge that sees run=1
// (LOAD->FETCH); every instruction then costs two edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tt_cpu_core;
  import tt_cpu_pkg::*;

  localparam int DATA_W     = 8;
  localparam int IMEM_DEPTH = 16;
  localparam int NUM_REGS   = 4;
  localparam int AW         = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          run;
  logic [AW-1:0] pc;
  logic          halted;
`ifdef CPU_BREAK_EN
  logic          bp_en;
  logic [AW-1:0] bp_addr;
  logic          bp_hit;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] prog_q [$];

  tt_cpu_if #(.DATA_W(DATA_W)) bus ();

  tt_cpu_core #(
    .DATA_W     (DATA_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .NUM_REGS   (NUM_REGS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .run     (run),
    .bus     (bus),
`ifdef CPU_BREAK_EN
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .bp_hit  (bp_hit),
`endif
    .pc      (pc),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input opcode_e op, input logic [3:0] r, input logic [7:0] imm);
    prog_q.push_back({op, r, imm});
  endtask

  // Offers every queued word for one cycle each; counts words taken.
  task automatic load_prog(output int accepted);
    accepted = 0;
    foreach (prog_q[i]) begin
      bus.prog_valid = 1'b1;
      bus.prog_data  = prog_q[i];
      if (bus.prog_ready === 1'b1) accepted++;
      tick();
    end
    bus.prog_valid = 1'b0;
    bus.prog_data  = '0;
    prog_q.delete();
  endtask

  // Clocks until out_valid (bounded), then checks edge count and data.
  task automatic wait_pulse(input string tag, input logic [7:0] exp_data, input int exp_edges);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.out_valid !== 1'b1 && n < 64);
    check({tag, "_seen"},  {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_edges"}, n, exp_edges);
    check({tag, "_data"},  {24'd0, bus.out_data}, {24'd0, exp_data});
  endtask

  initial begin
    int acc_n;

    rst            = 1'b1;
    ena            = 1'b1;
    run            = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_data  = '0;
    bus.in_data    = '0;
`ifdef CPU_BREAK_EN
    bp_en          = 1'b0;
    bp_addr        = '0;
`endif

    // ---- reset state ----
    tick();
    tick();
    check("rst_pc",         {28'd0, pc}, 32'd0);
    check("rst_halted",     {31'd0, halted}, 32'd0);
    check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",   {24'd0, bus.out_data}, 32'd0);
    check("rst_prog_ready", {31'd0, bus.prog_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // ---- T1: LDI 5, ADDI 3, OUT, HALT ----
    add(OP_LDI, 4'd0, 8'd5);
    add(OP_ADDI, 4'd0, 8'd3);
    add(OP_OUT, 4'd0, 8'd0);
    add(OP_HALT, 4'd0, 8'd0);
    load_prog(acc_n);
    check("t1_accepted", acc_n, 32'd4);
    run = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("t1_out_valid_e%0d", e), {31'd0, bus.out_valid}, (e == 7) ? 32'd1 : 32'd0);
      check($sformatf("t1_halted_e%0d", e), {31'd0, halted}, (e >= 9) ? 32'd1 : 32'd0);
      if (e == 7) check("t1_out_data", {24'd0, bus.out_data}, 32'd8);
    end
    check("t1_halt_pc", {28'd0, pc}, 32'd4);
    run = 1'b0;
    tick();
    check("t1_leave_halted", {31'd0, halted}, 32'd0);
    check("t1_leave_pc",     {28'd0, pc}, 32'd0);
    check("t1_leave_ready",  {31'd0, bus.prog_ready}, 32'd1);

    // ---- T2: carry/zero from ADDI wrap, JC and JZ taken ----
    add(OP_LDI,  4'd0, 8'hFF);  // 0
    add(OP_ADDI, 4'd0, 8'h01);  // 1: acc=0, Z=1, C=1
    add(OP_JC,   4'd0, 8'd5);   // 2
    add(OP_LDI,  4'd0, 8'h11);  // 3: skipped
    add(OP_OUT,  4'd0, 8'd0);   // 4: skipped
    add(OP_JZ,   4'd0, 8'd7);   // 5
    add(OP_HALT, 4'd0, 8'd0);   // 6: skipped
    add(OP_OUT,  4'd0, 8'd0);   // 7: outputs 0
    add(OP_HALT, 4'd0, 8'd0);   // 8
    load_prog(acc_n);
    run = 1'b1;
    wait_pulse("t2_out", 8'h00, 11);
    tick();
    tick();
    check("t2_halted", {31'd0, halted}, 32'd1);
    check("t2_pc",     {28'd0, pc}, 32'd9);
    run = 1'b0;
    tick();

    // ---- T3: full memory + 2 extras, SUB/borrow, XOR/IN/OR/AND, pc wrap ----
    add(OP_LDI,  4'd0, 8'd3);   // 0
    add(OP_MOV,  4'd1, 8'd0);   // 1: R1=3
    add(OP_LDI,  4'd0, 8'd5);   // 2
    add(OP_SUB,  4'd1, 8'd0);   // 3: acc=2, C=0
    add(OP_JC,   4'd0, 8'd8);   // 4: not taken
    add(OP_OUT,  4'd0, 8'd0);   // 5: 02
    add(OP_SUB,  4'd1, 8'd0);   // 6: acc=FF, C=1
    add(OP_JC,   4'd0, 8'd9);   // 7: taken
    add(OP_HALT, 4'd0, 8'd0);   // 8: skipped
    add(OP_XOR,  4'd1, 8'd0);   // 9: FC
    add(OP_OUT,  4'd0, 8'd0);   // 10
    add(OP_IN,   4'd0, 8'd0);   // 11: 5A
    add(OP_OR,   4'd1, 8'd0);   // 12: 5B
    add(OP_OUT,  4'd0, 8'd0);   // 13
    add(OP_AND,  4'd1, 8'd0);   // 14: 03
    add(OP_OUT,  4'd0, 8'd0);   // 15
    add(OP_HALT, 4'd0, 8'd0);   // extra, must be ignored
    add(OP_HALT, 4'd0, 8'd0);   // extra, must be ignored
    load_prog(acc_n);
    check("t3_accepted",   acc_n, 32'd16);
    check("t3_ready_full", {31'd0, bus.prog_ready}, 32'd0);
    bus.in_data = 8'h5A;
    run = 1'b1;
    wait_pulse("t3_sub",    8'h02, 13);
    wait_pulse("t3_borrow", 8'hFC, 8);
    wait_pulse("t3_in_or",  8'h5B, 6);
    wait_pulse("t3_and",    8'h03, 4);
    check("t3_pc_wrap", {28'd0, pc}, 32'd0);
    wait_pulse("t3_wrap",   8'h02, 12);
    check("t3_not_halted", {31'd0, halted}, 32'd0);
    run = 1'b0;
    tick();

    // ---- T4: ena stall in a counting loop ----
    add(OP_LDI, 4'd0, 8'd1);    // 0
    add(OP_MOV, 4'd0, 8'd0);    // 1: R0=1
    add(OP_LDI, 4'd0, 8'd0);    // 2
    add(OP_ADD, 4'd0, 8'd0);    // 3: acc+=1
    add(OP_OUT, 4'd0, 8'd0);    // 4
    add(OP_JMP, 4'd0, 8'd3);    // 5
    load_prog(acc_n);
    run = 1'b1;
    wait_pulse("t4_first",  8'd1, 11);
    wait_pulse("t4_second", 8'd2, 6);
    ena = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      tick();
      check($sformatf("t4_stall%0d_out_valid", s), {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("t4_stall%0d_pc", s),        {28'd0, pc}, 32'd5);
      check($sformatf("t4_stall%0d_out_data", s),  {24'd0, bus.out_data}, 32'd2);
    end
    ena = 1'b1;
    wait_pulse("t4_resume", 8'd3, 6);

    // ---- T5: async reset during EXEC of OUT ----
    for (int s = 0; s < 5; s++) tick();
    check("t5_pre_pc", {28'd0, pc}, 32'd5);
    #1 rst = 1'b1;
    #1;
    check("t5_async_pc",        {28'd0, pc}, 32'd0);
    check("t5_async_out_data",  {24'd0, bus.out_data}, 32'd0);
    check("t5_async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_async_halted",    {31'd0, halted}, 32'd0);
    tick();
    check("t5_no_pulse", {31'd0, bus.out_valid}, 32'd0);
    run = 1'b0;
    #1;
    check("t5_ready", {31'd0, bus.prog_ready}, 32'd1);
    rst = 1'b0;
    tick();
    // imem survives reset: rerun the loop without reloading.
    run = 1'b1;
    wait_pulse("t5_imem_kept", 8'd1, 11);
    run = 1'b0;
    tick();

`ifdef CPU_BREAK_EN
    // ---- T6: breakpoint at pc=2 ----
    add(OP_LDI,  4'd0, 8'd7);   // 0
    add(OP_OUT,  4'd0, 8'd0);   // 1
    add(OP_ADDI, 4'd0, 8'd1);   // 2: must not execute
    add(OP_OUT,  4'd0, 8'd0);   // 3
    load_prog(acc_n);
    bp_en   = 1'b1;
    bp_addr = 4'd2;
    run     = 1'b1;
    wait_pulse("t6_first", 8'd7, 5);
    tick();
    check("t6_halted", {31'd0, halted}, 32'd1);
    check("t6_bp_hit", {31'd0, bp_hit}, 32'd1);
    check("t6_pc",     {28'd0, pc}, 32'd2);
    tick();
    tick();
    check("t6_hold_pc",       {28'd0, pc}, 32'd2);
    check("t6_hold_out_data", {24'd0, bus.out_data}, 32'd7);
    run = 1'b0;
    tick();
    check("t6_leave_halted", {31'd0, halted}, 32'd0);
    check("t6_leave_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("t6_leave_pc",     {28'd0, pc}, 32'd0);
    run = 1'b1;
    wait_pulse("t6_restart", 8'd7, 5);
    run   = 1'b0;
    bp_en = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
